// File: rtl/mii_64b66b_encoder_if.sv
// MII-side input word and coded-block output bundle for the 64b/66b encoder.
// Latency: n/a (wires only).
// Backpressure: none; one word in and one block out per clock.
interface mii_64b66b_encoder_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    i_tx_data;
    logic [CTRL_WIDTH-1:0]    i_tx_ctrl;
    logic [65:0]              o_tx_coded;
    logic                     o_block_err;
    logic [ERR_CNT_WIDTH-1:0] o_err_count;

    // Frame generator side: drives MII words, observes coded blocks.
    modport master (
        output i_tx_data, i_tx_ctrl,
        input  o_tx_coded, o_block_err, o_err_count
    );

    // Encoder side.
    modport slave (
        input  i_tx_data, i_tx_ctrl,
        output o_tx_coded, o_block_err, o_err_count
    );
endinterface

// File: rtl/mii_64b66b_encoder.sv
// 64b/66b BASE-R transmit encoder (unscrambled): MII word -> 66-bit block, illegal sequences -> E block.
// Latency: 1 clock from input sample to o_tx_coded.
// Backpressure: none; one block is emitted every clock unconditionally.
module mii_64b66b_encoder #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         CTRL_WIDTH    = 8,
    parameter logic [7:0] IDLE_CODE     = 8'h07,
    parameter logic [7:0] START_CODE    = 8'hFB,
    parameter logic [7:0] TERM_CODE     = 8'hFD,
    parameter logic [7:0] ERROR_CODE    = 8'hFE,
    parameter int         ERR_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    mii_64b66b_encoder_if.slave tx_if
);

    localparam int          LANES    = DATA_WIDTH / 8;
    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b10};
    localparam logic [65:0] EBLK     = {{8{7'h1E}}, 8'h1E, 2'b10};

    typedef enum logic [1:0] {TX_C, TX_D, TX_T, TX_E} state_t;
    typedef enum logic [2:0] {CL_D, CL_C, CL_S, CL_T, CL_E} cls_t;

    state_t                   state_q, state_d;
    cls_t                     cls;
    logic                     all_c;
    logic                     t_ok;
    logic                     t_hit;
    logic [2:0]               t_lane;
    logic [55:0]              c_payload;
    logic [55:0]              t_payload;
    logic [65:0]              tx_coded_q, tx_coded_d;
    logic                     block_err_q, block_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    // Block type field for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    term_type = 8'h87;
            3'd1:    term_type = 8'h99;
            3'd2:    term_type = 8'hAA;
            3'd3:    term_type = 8'hB4;
            3'd4:    term_type = 8'hCC;
            3'd5:    term_type = 8'hD2;
            3'd6:    term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
    endfunction

    // Classify the incoming word; also builds the 7-bit control payload and finds a terminate lane.
    always_comb begin
        all_c     = 1'b1;
        c_payload = '0;
        t_ok      = 1'b0;
        t_hit     = 1'b0;
        t_lane    = '0;
        for (int k = 0; k < LANES; k++) begin
            if (tx_if.i_tx_data[8*k +: 8] == IDLE_CODE) begin
                c_payload[7*k +: 7] = 7'h00;
            end else if (tx_if.i_tx_data[8*k +: 8] == ERROR_CODE) begin
                c_payload[7*k +: 7] = 7'h1E;
            end else begin
                all_c = 1'b0;
            end
        end
        // Terminate in lane k: data below it, idles (as control) above it.
        for (int k = 0; k < LANES; k++) begin
            t_ok = tx_if.i_tx_ctrl[k] && (tx_if.i_tx_data[8*k +: 8] == TERM_CODE);
            for (int j = 0; j < LANES; j++) begin
                if (j < k) begin
                    t_ok = t_ok && !tx_if.i_tx_ctrl[j];
                end else if (j > k) begin
                    t_ok = t_ok && tx_if.i_tx_ctrl[j] && (tx_if.i_tx_data[8*j +: 8] == IDLE_CODE);
                end
            end
            if (t_ok) begin
                t_hit  = 1'b1;
                t_lane = 3'(k);
            end
        end
        if (tx_if.i_tx_ctrl == {CTRL_WIDTH{1'b0}}) begin
            cls = CL_D;
        end else if (tx_if.i_tx_ctrl == {CTRL_WIDTH{1'b1}} && all_c) begin
            cls = CL_C;
        end else if (tx_if.i_tx_ctrl == CTRL_WIDTH'(1) && tx_if.i_tx_data[7:0] == START_CODE) begin
            cls = CL_S;
        end else if (t_hit) begin
            cls = CL_T;
        end else begin
            cls = CL_E;
        end
    end

    // Terminate payload: data lanes below the terminate, everything else zero.
    always_comb begin
        t_payload = '0;
        for (int b = 0; b < LANES - 1; b++) begin
            if (3'(b) < t_lane) begin
                t_payload[8*b +: 8] = tx_if.i_tx_data[8*b +: 8];
            end
        end
    end

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= TX_C;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state from the current state and the input class.
    always_comb begin
        state_d = TX_E;
        case (state_q)
            TX_C, TX_T: begin
                case (cls)
                    CL_C:    state_d = TX_C;
                    CL_S:    state_d = TX_D;
                    default: state_d = TX_E;
                endcase
            end
            TX_D: begin
                case (cls)
                    CL_D:    state_d = TX_D;
                    CL_T:    state_d = TX_T;
                    default: state_d = TX_E;
                endcase
            end
            default: begin
                case (cls)
                    CL_D:    state_d = TX_D;
                    CL_T:    state_d = TX_T;
                    CL_C:    state_d = TX_C;
                    default: state_d = TX_E;
                endcase
            end
        endcase
    end

    // Output block: every transition into TX_E is exactly the set of cycles that emit EBLK.
    always_comb begin
        case (cls)
            CL_D:    tx_coded_d = {tx_if.i_tx_data, 2'b01};
            CL_C:    tx_coded_d = {c_payload, 8'h1E, 2'b10};
            CL_S:    tx_coded_d = {tx_if.i_tx_data[DATA_WIDTH-1:8], 8'h78, 2'b10};
            CL_T:    tx_coded_d = {t_payload, term_type(t_lane), 2'b10};
            default: tx_coded_d = EBLK;
        endcase
        block_err_d = (state_d == TX_E);
        if (block_err_d) begin
            tx_coded_d = EBLK;
        end
        err_count_d = err_count_q;
        if (block_err_d && err_count_q != {ERR_CNT_WIDTH{1'b1}}) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Output registers: block, error flag and saturating error counter move together.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            tx_coded_q  <= IDLE_BLK;
            block_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            tx_coded_q  <= tx_coded_d;
            block_err_q <= block_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign tx_if.o_tx_coded  = tx_coded_q;
    assign tx_if.o_block_err = block_err_q;
    assign tx_if.o_err_count = err_count_q;

endmodule
